// File: rtl/fifo_burst_reader.sv
// Read-side master for the synchronous FIFO: pops words and forwards them downstream as
// framed bursts with a last-beat flag; a wait-state timer flushes stragglers as 1-beat bursts.
// state   | meaning
// S_IDLE  | disabled, no bursts start
// S_WAIT  | armed, waiting for FIFO level or timeout
// S_BURST | popping beats until the latched length is reached
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int TIMEOUT    = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic [ADDR_WIDTH:0]   i_burst_len,
  input  logic                  i_valid_m,
  input  logic                  i_almostempty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_ready_m,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_underrun
);

  localparam int LW        = ADDR_WIDTH + 1;
  localparam int TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t                state_q, state_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic                  underrun_q, underrun_d;

  logic                  pop;
  logic                  beat_last;
  logic [LW-1:0]         len_clamped;

  always_comb begin
    if (i_burst_len == '0) begin
      len_clamped = LW'(1);
    end else if (i_burst_len > LW'(FIFO_DEPTH)) begin
      len_clamped = LW'(FIFO_DEPTH);
    end else begin
      len_clamped = i_burst_len;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    valid_d    = valid_q;
    data_d     = data_q;
    last_d     = last_q;
    underrun_d = underrun_q;

    // Never pop while a held word is still waiting for the sink.
    pop       = (state_q == S_BURST) & i_valid_m & (~valid_q | i_ready);
    beat_last = (cnt_q == (len_q - LW'(1)));

    if (pop) begin
      valid_d = 1'b1;
      data_d  = i_fifo_data;
      last_d  = beat_last;
    end else if (i_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (i_enable) begin
          state_d = S_WAIT;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        if (i_valid_m & ~i_almostempty) begin
          len_d   = len_clamped;
          cnt_d   = '0;
          state_d = S_BURST;
        end else if ((TIMEOUT != 0) && (timer_q == TW'(TO_LAST_I)) && i_valid_m) begin
          len_d   = LW'(1);
          cnt_d   = '0;
          state_d = S_BURST;
        end else if (~i_enable & ~i_valid_m) begin
          state_d = S_IDLE;
        end else if (i_valid_m & i_almostempty) begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_BURST: begin
        if (~i_valid_m) begin
          underrun_d = 1'b1;
        end
        if (pop) begin
          cnt_d = cnt_q + LW'(1);
          if (beat_last) begin
            state_d = i_enable ? S_WAIT : S_IDLE;
            timer_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      timer_q    <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      last_q     <= last_d;
      underrun_q <= underrun_d;
    end
  end

  assign o_ready_m  = pop;
  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_last     = last_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_underrun = underrun_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a behavioural FIFO feeds the DUT, a sink logs accepted beats.
module tb_fifo_burst_reader;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NV = 8;

  logic          clk = 1'b0;
  logic          rst, enable, ready, flush;
  logic [AW:0]   burst_len;
  logic          valid_m, almostempty, ready_m, o_valid, o_last, busy, underrun;
  logic [DW-1:0] fifo_data, o_data;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_WIDTH(DW), .FIFO_DEPTH(16), .ADDR_WIDTH(AW), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_burst_len(burst_len),
    .i_valid_m(valid_m), .i_almostempty(almostempty), .i_fifo_data(fifo_data),
    .o_ready_m(ready_m), .o_valid(o_valid), .o_data(o_data), .o_last(o_last),
    .i_ready(ready), .o_busy(busy), .o_underrun(underrun)
  );

  // Behavioural FIFO: level-based almost-empty, popped on o_ready_m & valid.
  logic [DW-1:0] mem [0:255];
  logic [7:0]    wr_ptr = 8'd0;
  logic [7:0]    rd_ptr = 8'd0;
  logic [7:0]    ae_level;
  wire  [7:0]    fill = wr_ptr - rd_ptr;
  assign valid_m     = (fill != 8'd0);
  assign almostempty = (fill <= ae_level);
  assign fifo_data   = mem[rd_ptr];

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (ready_m && valid_m) rd_ptr <= rd_ptr + 8'd1;
  end

  // Sink log plus hold-stability monitor.
  logic [DW-1:0] acc_data[$];
  logic          acc_last[$];
  logic          held_q = 1'b0;
  logic [DW-1:0] held_data;
  logic          held_last;
  int            hold_viol = 0;

  always @(posedge clk) begin
    if (o_valid && ready) begin
      acc_data.push_back(o_data);
      acc_last.push_back(o_last);
    end
    if (held_q && (o_data !== held_data || o_last !== held_last || !o_valid))
      hold_viol <= hold_viol + 1;
    held_q    <= o_valid && !ready && !rst;
    held_data <= o_data;
    held_last <= o_last;
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [AW:0] len;
    int          nwords;
    int          exp_burst;
    bit          bp;
    logic [7:0]  base;
  } vec_t;
  vec_t vecs[NV];

  int            start, cyc, first, rdy_cnt, dlast;
  logic [DW-1:0] first_data, exp_d;
  logic          first_last, exp_l, found;

  initial begin
    vecs[0] = '{5'd4,  8,  4,  1'b0, 8'h10};
    vecs[1] = '{5'd4,  8,  4,  1'b1, 8'h20};
    vecs[2] = '{5'd0,  3,  1,  1'b0, 8'h30};
    vecs[3] = '{5'd1,  2,  1,  1'b1, 8'h38};
    vecs[4] = '{5'd20, 32, 16, 1'b0, 8'h40};
    vecs[5] = '{5'd16, 16, 16, 1'b1, 8'h70};
    vecs[6] = '{5'd2,  6,  2,  1'b0, 8'h90};
    vecs[7] = '{5'd17, 16, 16, 1'b0, 8'hA0};

    rst = 1'b1; enable = 1'b0; ready = 1'b1; flush = 1'b0;
    burst_len = 5'd4; ae_level = 8'd0;
    tick(2);
    check("rst o_valid", o_valid, 0);
    check("rst o_data", o_data, 0);
    check("rst o_last", o_last, 0);
    check("rst o_underrun", underrun, 0);
    check("rst o_busy", busy, 0);
    check("rst o_ready_m", ready_m, 0);
    rst = 1'b0; enable = 1'b1;
    tick(1);
    check("enable busy", busy, 1);

    // Full 4-beat burst from six preloaded words; two remain below the level.
    ae_level = 8'd2;
    for (int i = 0; i < 6; i++) push(32'hA0 + i);
    rdy_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ready_m) rdy_cnt++;
      if (k >= 2 && k <= 5) begin
        check($sformatf("full beat%0d", k - 1),
              {o_valid, o_last, o_data}, {1'b1, (k == 5), 32'hA0 + k - 2});
      end
    end
    check("full ready_m cycles", rdy_cnt, 4);
    check("full back in wait", busy, 1);
    check("full accepted", acc_data.size(), 4);
    cyc = 0;
    while (acc_data.size() < 6 && cyc < 60) begin tick(1); cyc++; end
    check("straggler count", acc_data.size(), 6);
    if (acc_data.size() >= 6) begin
      check("straggler A4", {acc_last[4], acc_data[4]}, {1'b1, 32'hA4});
      check("straggler A5", {acc_last[5], acc_data[5]}, {1'b1, 32'hA5});
    end

    // Timeout latency measured from the cycle enable re-arms the block.
    enable = 1'b0;
    tick(3);
    check("disable idle", busy, 0);
    push(32'h55);
    enable = 1'b1;
    first = 0; first_data = '0; first_last = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (o_valid && first == 0) begin
        first = k; first_data = o_data; first_last = o_last;
      end
    end
    check("timeout latency", first, 10);
    check("timeout word", {first_last, first_data}, {1'b1, 32'h55});

    ae_level = 8'd0;
    for (int v = 0; v < NV; v++) begin
      burst_len = vecs[v].len;
      start = acc_data.size();
      for (int i = 0; i < vecs[v].nwords; i++) push((32'(vecs[v].base) << 8) + i);
      cyc = 0;
      while (acc_data.size() < start + vecs[v].nwords && cyc < 400) begin
        @(negedge clk);
        cyc++;
        ready = vecs[v].bp ? ~ready : 1'b1;
      end
      ready = 1'b1;
      tick(4);
      check($sformatf("v%0d count", v), acc_data.size() - start, vecs[v].nwords);
      for (int i = 0; i < vecs[v].nwords; i++) begin
        if (start + i < acc_data.size()) begin
          exp_d = (32'(vecs[v].base) << 8) + i;
          exp_l = ((i % vecs[v].exp_burst) == vecs[v].exp_burst - 1);
          check($sformatf("v%0d beat%0d", v, i),
                {acc_last[start + i], acc_data[start + i]}, {exp_l, exp_d});
        end
      end
    end
    check("hold stable", hold_viol, 0);
    check("no underrun yet", underrun, 0);

    // Underrun: two of four beats available, then the rest arrive.
    burst_len = 5'd4;
    start = acc_data.size();
    push(32'hC0); push(32'hC1);
    tick(8);
    check("underrun partial", acc_data.size() - start, 2);
    check("underrun flag", underrun, 1);
    check("underrun stalled busy", {busy, o_valid}, {1'b1, 1'b0});
    if (acc_data.size() >= start + 2) check("underrun no early last", {acc_last[start], acc_last[start + 1]}, 0);
    push(32'hC2); push(32'hC3);
    cyc = 0;
    while (acc_data.size() < start + 4 && cyc < 40) begin tick(1); cyc++; end
    check("underrun resume", acc_data.size() - start, 4);
    if (acc_data.size() >= start + 4) begin
      check("underrun C2", {acc_last[start + 2], acc_data[start + 2]}, {1'b0, 32'hC2});
      check("underrun C3", {acc_last[start + 3], acc_data[start + 3]}, {1'b1, 32'hC3});
    end
    check("underrun sticky", underrun, 1);

    // Reset while beat 2 of a 4-beat burst is on the output.
    start = acc_data.size();
    for (int i = 0; i < 4; i++) push(32'hD0 + i);
    found = 1'b0; cyc = 0;
    while (!found && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (o_valid && o_data == 32'hD1) found = 1'b1;
    end
    check("midrst reached beat2", found, 1);
    rst = 1'b1; flush = 1'b1; enable = 1'b0;
    tick(1);
    check("midrst outputs", {o_valid, o_last, busy, underrun}, 0);
    rst = 1'b0; flush = 1'b0;
    tick(5);
    check("midrst stays idle", {busy, o_valid}, 0);
    dlast = 0;
    for (int i = start; i < acc_data.size(); i++) if (acc_last[i]) dlast++;
    check("midrst no last", dlast, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
